// File: rtl/sram_responder_pkg.sv
// cpu_pkg -- shared sizing constants and responder state encodings.
//   ADDR_W  : word-address width of the CPU SRAM
//   DATA_W  : data word width
//   DEPTH   : number of storage words (2**ADDR_W)
//   state_t : LOAD / RUN / ERR encodings of the responder FSM
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if -- CPU SRAM bus plus loader stream of the responder.
//   CPU side   : sram_addr, sram_din, we (to responder), sram_dout (from responder)
//   Loader side: ld_valid, ld_data, ld_last (to responder), ld_ready (from responder)
//   Status     : cpu_hold, ld_err, ld_count (from responder)
//   master modport drives requests, slave modport is the responder.
interface sram_responder_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic              we;
    logic [DATA_W-1:0] sram_dout;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              cpu_hold;
    logic              ld_err;
    logic [ADDR_W:0]   ld_count;

    modport master (
        output sram_addr, sram_din, we, ld_valid, ld_data, ld_last,
        input  sram_dout, ld_ready, cpu_hold, ld_err, ld_count
    );

    modport slave (
        input  sram_addr, sram_din, we, ld_valid, ld_data, ld_last,
        output sram_dout, ld_ready, cpu_hold, ld_err, ld_count
    );
endinterface

// File: rtl/sram_responder_array.sv
// sram_array -- word storage with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never cleared.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (same-cycle)
module sram_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read: a write on this edge becomes visible only after it.
    assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// sram_responder -- boot loader + CPU SRAM responder.
// After reset the block is in LOAD: it streams loader words into memory from
// address 0 upward while holding the CPU in reset. A word flagged ld_last
// moves it to RUN, where the CPU reads combinationally and writes on the
// clock edge. Filling the last address without ld_last is an overflow: the
// block parks in ERR until reset.
//   clk : clock (rising edge)
//   rst : asynchronous, active-low reset
//   bus : sram_responder_if slave (CPU bus, loader stream, status)
module sram_responder #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    sram_responder_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // drives them to their LOAD values immediately.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        count_next    = count_reg;
        wr_en         = 1'b0;
        wr_addr       = bus.sram_addr;
        wr_data       = bus.sram_din;
        bus.ld_ready  = 1'b0;
        bus.cpu_hold  = 1'b1;
        bus.ld_err    = 1'b0;
        bus.sram_dout = '0;

        case (state_reg)
            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_reg;
                    wr_data = bus.ld_data;
                    if (count_reg != FULL_COUNT) begin
                        count_next = count_reg + (ADDR_W + 1)'(1);
                    end
                    // Pointer stops at the top word instead of wrapping.
                    if (ptr_reg != LAST_PTR) begin
                        ptr_next = ptr_reg + ADDR_W'(1);
                    end
                    if (bus.ld_last) begin
                        state_next = ST_RUN;
                    end else if (ptr_reg == LAST_PTR) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_RUN: begin
                bus.cpu_hold  = 1'b0;
                bus.sram_dout = rd_data;
                wr_en         = bus.we;
            end
            ST_ERR: begin
                bus.ld_err = 1'b1;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    assign bus.ld_count = count_reg;

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (bus.sram_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder -- scenario tasks for the loader/CPU SRAM responder.
// A shadow memory supplies expected read data; expected words are queued
// when a read address is driven and popped when sram_dout is sampled.
module tb_sram_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    sram_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] model [4096];
    logic [15:0] exp_q [$];
    int          exp_ptr;
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        bus.we        = 1'b0;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        model[exp_ptr[11:0]] = d;
        exp_ptr++;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        exp_ptr = 0;
        @(negedge clk);
        n_cmp += 5;
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", bus.ld_ready); end
        if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 1", bus.cpu_hold); end
        if (bus.ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err: got %b expected 0", bus.ld_err); end
        if (bus.ld_count !== 13'd0) begin n_fail++; $display("FAIL reset_ld_count: got %0d expected 0", bus.ld_count); end
        if (bus.sram_dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", bus.sram_dout); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_load_basic();
        logic [15:0] words [3];
        logic [15:0] got, exp;
        words[0] = 16'h7800; words[1] = 16'h7020; words[2] = 16'h7001;
        test_reset();
        load_word(words[0], 1'b0);
        load_word(words[1], 1'b0);
        // Third word driven but its edge not yet taken: still loading.
        bus.ld_valid = 1'b1; bus.ld_data = words[2]; bus.ld_last = 1'b1;
        model[2] = words[2]; exp_ptr++;
        @(negedge clk);
        n_cmp++;
        if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_before_last: got %b expected 1", bus.cpu_hold); end
        step();
        idle_inputs();
        @(negedge clk);
        n_cmp += 3;
        if (bus.ld_count !== 13'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", bus.ld_count); end
        if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_hold: got %b expected 0", bus.cpu_hold); end
        if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ld_ready: got %b expected 0", bus.ld_ready); end
        for (int a = 0; a < 3; a++) begin
            step();
            bus.sram_addr = 12'(a);
            exp_q.push_back(words[a]);
            @(negedge clk);
            got = bus.sram_dout;
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL basic_read[%0d]: got %h expected %h", a, got, exp); end
        end
        step();
    endtask

    task automatic test_run_write();
        logic [15:0] got, exp;
        // Seed a known old value, then overwrite it.
        bus.we = 1'b1; bus.sram_addr = 12'h010; bus.sram_din = 16'h1111;
        model[12'h010] = 16'h1111;
        step();
        bus.sram_din = 16'hBEEF;
        exp_q.push_back(model[12'h010]);
        @(negedge clk);
        got = bus.sram_dout; exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rdw_old_value: got %h expected %h", got, exp); end
        model[12'h010] = 16'hBEEF;
        step();
        bus.we = 1'b0;
        exp_q.push_back(model[12'h010]);
        @(negedge clk);
        got = bus.sram_dout; exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rdw_new_value: got %h expected %h", got, exp); end
        // Loader inputs are ignored in RUN.
        bus.ld_valid = 1'b1; bus.ld_data = 16'hDEAD; bus.ld_last = 1'b1;
        step();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        bus.sram_addr = 12'h000;
        exp_q.push_back(model[0]);
        @(negedge clk);
        got = bus.sram_dout; exp = exp_q.pop_front();
        n_cmp += 2;
        if (got !== exp) begin n_fail++; $display("FAIL run_ignores_loader: got %h expected %h", got, exp); end
        if (bus.ld_count !== 13'd3) begin n_fail++; $display("FAIL run_count_hold: got %0d expected 3", bus.ld_count); end
        step();
    endtask

    task automatic test_load_we_ignored();
        logic [15:0] got, exp;
        bus.we = 1'b1; bus.sram_addr = 12'h005; bus.sram_din = 16'h5A5A;
        model[5] = 16'h5A5A;
        step();
        bus.we = 1'b0;
        test_reset();
        bus.we = 1'b1; bus.sram_addr = 12'h005; bus.sram_din = 16'h1234;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.sram_dout !== 16'h0) begin n_fail++; $display("FAIL load_dout_zero[%0d]: got %h expected 0000", c, bus.sram_dout); end
            step();
        end
        bus.we = 1'b0;
        load_word(16'h0F0F, 1'b1);
        bus.sram_addr = 12'h005;
        exp_q.push_back(model[5]);
        @(negedge clk);
        got = bus.sram_dout; exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL load_we_ignored: got %h expected %h", got, exp); end
        step();
    endtask

    task automatic test_load_gaps();
        logic [15:0] got, exp;
        logic        v [5];
        logic [15:0] d [5];
        v[0] = 1; v[1] = 0; v[2] = 0; v[3] = 1; v[4] = 1;
        d[0] = 16'hA001; d[1] = 16'hBAD1; d[2] = 16'hBAD2; d[3] = 16'hA002; d[4] = 16'hA003;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            if (v[i]) begin
                load_word(d[i], i == 4);
            end else begin
                bus.ld_data = d[i];
                step();
            end
        end
        @(negedge clk);
        n_cmp += 2;
        if (bus.ld_count !== 13'd3) begin n_fail++; $display("FAIL gaps_count: got %0d expected 3", bus.ld_count); end
        if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL gaps_run: got %b expected 0", bus.cpu_hold); end
        for (int a = 0; a < 3; a++) begin
            step();
            bus.sram_addr = 12'(a);
            exp_q.push_back(model[a]);
            @(negedge clk);
            got = bus.sram_dout; exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL gaps_read[%0d]: got %h expected %h", a, got, exp); end
        end
        step();
    endtask

    task automatic test_reset_midload();
        logic [15:0] got, exp;
        test_reset();
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        bus.ld_valid = 1'b1; bus.ld_data = 16'h3333;
        #2;
        rst = 1'b0;
        #1;
        n_cmp += 3;
        if (bus.ld_count !== 13'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", bus.ld_count); end
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", bus.ld_ready); end
        if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midreset_hold: got %b expected 1", bus.cpu_hold); end
        bus.ld_valid = 1'b0;
        step();
        rst = 1'b1;
        exp_ptr = 0;
        load_word(16'hC0DE, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (bus.ld_count !== 13'd1) begin n_fail++; $display("FAIL midreset_newcount: got %0d expected 1", bus.ld_count); end
        for (int a = 0; a < 2; a++) begin
            step();
            bus.sram_addr = 12'(a);
            exp_q.push_back(model[a]);
            @(negedge clk);
            got = bus.sram_dout; exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL midreset_read[%0d]: got %h expected %h", a, got, exp); end
        end
        step();
    endtask

    task automatic test_overflow();
        logic [15:0] got, exp;
        logic [11:0] probe [2];
        probe[0] = 12'hFFF; probe[1] = 12'h800;
        test_reset();
        for (int i = 0; i < 4095; i++) begin
            load_word(16'(i * 7 + 3), 1'b0);
        end
        bus.ld_valid = 1'b1; bus.ld_data = 16'hE0E0; bus.ld_last = 1'b0;
        model[12'hFFF] = 16'hE0E0; exp_ptr++;
        @(negedge clk);
        n_cmp += 2;
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_last_word: got %b expected 1", bus.ld_ready); end
        if (bus.ld_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early: got %b expected 0", bus.ld_err); end
        step();
        bus.ld_data = 16'hFFFF; bus.ld_last = 1'b1;   // keep pushing: must be ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp += 5;
            if (bus.ld_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err[%0d]: got %b expected 1", c, bus.ld_err); end
            if (bus.ld_count !== 13'd4096) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d expected 4096", c, bus.ld_count); end
            if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL ovf_hold[%0d]: got %b expected 1", c, bus.cpu_hold); end
            if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready[%0d]: got %b expected 0", c, bus.ld_ready); end
            if (bus.sram_dout !== 16'h0) begin n_fail++; $display("FAIL ovf_dout[%0d]: got %h expected 0000", c, bus.sram_dout); end
            step();
        end
        idle_inputs();
        test_reset();
        load_word(16'h9999, 1'b1);
        for (int p = 0; p < 2; p++) begin
            bus.sram_addr = probe[p];
            exp_q.push_back(model[probe[p]]);
            @(negedge clk);
            got = bus.sram_dout; exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL ovf_read[%h]: got %h expected %h", probe[p], got, exp); end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_load_basic();
        test_run_write();
        test_load_we_ignored();
        test_load_gaps();
        test_reset_midload();
        test_overflow();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
